// File: rtl/pipe_pkg.sv
// pipe_pkg: per-stage data/control field widths shared by every pipeline register instance
package pipe_pkg;
   localparam int IF_ID_DATA_W  = 64;
   localparam int IF_ID_CTRL_W  = 2;
   localparam int ID_EX_DATA_W  = 139;
   localparam int ID_EX_CTRL_W  = 22;
   localparam int EX_MEM_DATA_W = 106;
   localparam int EX_MEM_CTRL_W = 12;
   localparam int MEM_WB_DATA_W = 71;
   localparam int MEM_WB_CTRL_W = 5;
endpackage

// File: rtl/pipe_skid_buffer_if.sv
// pipe_skid_buffer_if: valid/ready stream carrying a data field and a control field
interface pipe_skid_buffer_if #(
   parameter int DATA_W = pipe_pkg::ID_EX_DATA_W,
   parameter int CTRL_W = pipe_pkg::ID_EX_CTRL_W
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;
   modport master (output valid, data, ctrl, input ready);
   modport slave  (input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: one held beat (valid + data + ctrl) with load, clear and flush
module pipe_slot #(
   parameter int DATA_W = 8,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);
   // flush drops the beat and its ctrl but leaves data stale; load wins over clear
   always_ff @(posedge clk)
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= d_data;
         ctrl  <= d_ctrl;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end
endmodule

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: pipeline stage register with valid/ready handshake, optional skid entry and flush
module pipe_skid_buffer
   import pipe_pkg::*;
#(
   parameter int DATA_W  = ID_EX_DATA_W,
   parameter int CTRL_W  = ID_EX_CTRL_W,
   parameter bit SKID_EN = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   pipe_skid_buffer_if.slave   up,
   pipe_skid_buffer_if.master  dn,
   output logic [1:0]          occupancy
);
   logic              accept, consume, m_load, m_valid, s_valid;
   logic [DATA_W-1:0] m_data, s_data, m_d;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_c;
   // head refills from the skid first, otherwise straight from the input beat
   always_comb begin
      accept  = up.valid & up.ready;
      consume = m_valid & dn.ready;
      m_load  = (~m_valid | consume) & (s_valid | accept);
      m_d     = s_valid ? s_data : up.data;
      m_c     = s_valid ? s_ctrl : up.ctrl;
   end
   assign up.ready  = SKID_EN ? ~s_valid : (dn.ready | ~m_valid);
   assign dn.valid  = m_valid;
   assign dn.data   = m_data;
   assign dn.ctrl   = m_valid ? m_ctrl : '0;
   assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_m (
      .clk(clk), .reset(reset), .flush(flush), .load(m_load), .clear(consume),
      .d_data(m_d), .d_ctrl(m_c), .valid(m_valid), .data(m_data), .ctrl(m_ctrl)
   );
   generate
      if (SKID_EN) begin : g_skid
         pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_s (
            .clk(clk), .reset(reset), .flush(flush), .load(m_valid & ~consume & accept),
            .clear(consume), .d_data(up.data), .d_ctrl(up.ctrl),
            .valid(s_valid), .data(s_data), .ctrl(s_ctrl)
         );
      end else begin : g_no_skid
         assign s_valid = 1'b0;
         assign s_data  = '0;
         assign s_ctrl  = '0;
      end
   endgenerate
endmodule
